// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit
// Instruction memory plus fetch front end. Program words arrive through the
// load port while the core is idle. Once start is seen, the unit streams one
// instruction per cycle, with its word address, to decode. Decode can hold
// the stream with stall. The core can move it with a branch/jump redirect.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-high reset (memory contents survive)
//   start               run enable; fetching happens only while high
//   I_MEM_Write_Enable  load-port write strobe
//   I_MEM_Data_In       load-port write data
//   I_MEM_Write_Addr    load-port word address (16 bits, only < DEPTH accepted)
//   stall               decode cannot accept; all fetch outputs hold
//   redirect_valid      one-cycle taken branch/jump pulse, wins over stall
//   redirect_pc         redirect target word address (wraps modulo DEPTH)
//   instr_out           fetched instruction
//   instr_valid         instr_out/pc_out valid this cycle
//   pc_out              word address of instr_out, zero-extended to 32 bits
//   load_err            one-cycle pulse after a rejected load write
//   running             high while the fetch FSM is in RUN
module imem_fetch_unit #(
    parameter int DEPTH  = 256,
    parameter int AW     = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              I_MEM_Write_Enable,
    input  logic [DATA_W-1:0] I_MEM_Data_In,
    input  logic [15:0]       I_MEM_Write_Addr,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [15:0]       redirect_pc,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic [31:0]       pc_out,
    output logic              load_err,
    output logic              running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [31:0] DEPTH_W = DEPTH;

    state_t            state;
    state_t            next_state;
    logic [AW-1:0]     fetch_pc;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_in_range;
    logic              wr_accept;
    logic              unused_redirect_bits;

    // Redirect targets wrap modulo DEPTH, so the upper target bits are ignored.
    assign unused_redirect_bits = ^redirect_pc[15:AW];

    assign wr_in_range = ({16'b0, I_MEM_Write_Addr} < DEPTH_W);
    assign wr_accept   = I_MEM_Write_Enable && (state != RUN) && wr_in_range;

    // A write strobe always takes precedence over start. RUN is entered only
    // from IDLE, so a load that drops with start already high passes through
    // IDLE for one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (I_MEM_Write_Enable) begin
                    next_state = LOAD;
                end else if (start) begin
                    next_state = RUN;
                end
            end
            LOAD: begin
                if (!I_MEM_Write_Enable) begin
                    next_state = IDLE;
                end
            end
            RUN: begin
                if (!start) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= next_state;
            running <= (next_state == RUN);
        end
    end

    // The memory array has no reset, so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[I_MEM_Write_Addr[AW-1:0]] <= I_MEM_Data_In;
        end
    end

    // Any rejected write produces a one-cycle error pulse. This covers an
    // out-of-range address and any write attempted while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_err <= 1'b0;
        end else begin
            load_err <= I_MEM_Write_Enable && ((state == RUN) || !wr_in_range);
        end
    end

    // instr_out is the synchronous read register of the memory. Its address is
    // fetch_pc, which always points at the next word to hand out. A stalled
    // cycle skips the update, so the held word is simply read again on the
    // cycle the stall releases. A redirect (or the first RUN cycle) leaves one
    // bubble, because the new address is read on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_out   <= '0;
            instr_valid <= 1'b0;
            pc_out      <= '0;
            fetch_pc    <= '0;
        end else if (state == RUN) begin
            if (!start) begin
                instr_valid <= 1'b0;
                fetch_pc    <= '0;
            end else if (redirect_valid) begin
                instr_valid <= 1'b0;
                fetch_pc    <= redirect_pc[AW-1:0];
            end else if (!stall) begin
                instr_out   <= mem[fetch_pc];
                pc_out      <= {{(32-AW){1'b0}}, fetch_pc};
                instr_valid <= 1'b1;
                fetch_pc    <= fetch_pc + AW'(1);
            end
        end else begin
            instr_valid <= 1'b0;
            fetch_pc    <= '0;
        end
    end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit
// Directed testbench for imem_fetch_unit. It loads a small program, then
// exercises streaming, redirect, stall, rejected writes, PC wrap and reset
// in the middle of a run. Expected values come from the bench's own copy
// of the program and from hand-worked cycle timing.
module tb_imem_fetch_unit;

    localparam int DEPTH  = 256;
    localparam int AW     = 8;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic              I_MEM_Write_Enable;
    logic [DATA_W-1:0] I_MEM_Data_In;
    logic [15:0]       I_MEM_Write_Addr;
    logic              stall;
    logic              redirect_valid;
    logic [15:0]       redirect_pc;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic [31:0]       pc_out;
    logic              load_err;
    logic              running;

    logic [31:0] prog [DEPTH];
    int checks;
    int errors;

    imem_fetch_unit #(.DEPTH(DEPTH), .AW(AW), .DATA_W(DATA_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .I_MEM_Write_Enable (I_MEM_Write_Enable),
        .I_MEM_Data_In      (I_MEM_Data_In),
        .I_MEM_Write_Addr   (I_MEM_Write_Addr),
        .stall              (stall),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .instr_out          (instr_out),
        .instr_valid        (instr_valid),
        .pc_out             (pc_out),
        .load_err           (load_err),
        .running            (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [31:0] data);
        I_MEM_Write_Enable = 1'b1;
        I_MEM_Write_Addr   = 16'(addr);
        I_MEM_Data_In      = data;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; I_MEM_Write_Enable = 1'b0; I_MEM_Data_In = '0;
        I_MEM_Write_Addr = '0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (pc_out !== 32'd0) begin errors++; $display("[TB] FAIL reset_pc: got %h want 0", pc_out); end
        checks++; if (instr_out !== 32'd0) begin errors++; $display("[TB] FAIL reset_instr: got %h want 0", instr_out); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_err: got %b want 0", load_err); end
        checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL reset_running: got %b want 0", running); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_and_run();
        prog[0] = 32'h0000_0000;
        prog[1] = 32'hC821_0005;
        prog[2] = 32'hC842_000A;
        for (int i = 3; i < 27; i++) prog[i] = 32'h2000_0000 + 32'(i) * 32'h0001_0003;
        prog[44] = 32'h4444_AAAA;
        for (int i = 250; i < 256; i++) prog[i] = 32'hF000_0000 + 32'(i);
        for (int i = 0; i < 27; i++) load_word(i, prog[i]);
        load_word(44, prog[44]);
        for (int i = 250; i < 256; i++) load_word(i, prog[i]);
        checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL load_no_err: got %b want 0", load_err); end
        I_MEM_Write_Enable = 1'b0;
        tick();
        start = 1'b1;
        tick();
        checks++; if (running !== 1'b1) begin errors++; $display("[TB] FAIL run_entry_running: got %b want 1", running); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL run_entry_bubble: got %b want 0", instr_valid); end
        tick();
        for (int i = 0; i < 27; i++) begin
            if (i != 0) tick();
            checks++;
            if (instr_valid !== 1'b1 || pc_out !== 32'(i) || instr_out !== prog[i]) begin
                errors++;
                $display("[TB] FAIL stream_%0d: got v=%b pc=%0d instr=%h want v=1 pc=%0d instr=%h",
                         i, instr_valid, pc_out, instr_out, i, prog[i]);
            end
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 16'd0;
        tick();
        redirect_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL redirect_bubble: got %b want 0", instr_valid); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || pc_out !== 32'(i) || instr_out !== prog[i]) begin
                errors++;
                $display("[TB] FAIL redirect_target_%0d: got v=%b pc=%0d instr=%h want v=1 pc=%0d instr=%h",
                         i, instr_valid, pc_out, instr_out, i, prog[i]);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 2; i <= 5; i++) begin
            tick();
            checks++; if (pc_out !== 32'(i)) begin errors++; $display("[TB] FAIL pre_stall_pc: got %0d want %0d", pc_out, i); end
        end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || pc_out !== 32'd5 || instr_out !== prog[5]) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d: got v=%b pc=%0d instr=%h want v=1 pc=5 instr=%h",
                         k, instr_valid, pc_out, instr_out, prog[5]);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (pc_out !== 32'd6 || instr_out !== prog[6] || instr_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release: got v=%b pc=%0d instr=%h want v=1 pc=6 instr=%h",
                     instr_valid, pc_out, instr_out, prog[6]);
        end
    endtask

    task automatic test_load_err();
        start = 1'b0;
        tick();
        checks++; if (instr_valid !== 1'b0 || running !== 1'b0) begin errors++; $display("[TB] FAIL stop_run: got v=%b run=%b want 0 0", instr_valid, running); end
        checks++; if (pc_out !== 32'd6) begin errors++; $display("[TB] FAIL stop_keeps_pc: got %0d want 6", pc_out); end
        load_word(300, 32'hDEAD_BEEF);
        checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL oob_err_pulse: got %b want 1", load_err); end
        I_MEM_Write_Enable = 1'b0;
        tick();
        checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL oob_err_clear: got %b want 0", load_err); end
        start = 1'b1;
        tick(); tick(); tick();
        checks++; if (pc_out !== 32'd1 || instr_out !== prog[1]) begin errors++; $display("[TB] FAIL restart_pc1: got pc=%0d instr=%h want pc=1 instr=%h", pc_out, instr_out, prog[1]); end
        load_word(44, 32'h0BAD_0BAD);
        checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL run_write_err: got %b want 1", load_err); end
        checks++; if (pc_out !== 32'd2 || instr_out !== prog[2]) begin errors++; $display("[TB] FAIL run_write_fetch: got pc=%0d instr=%h want pc=2 instr=%h", pc_out, instr_out, prog[2]); end
        I_MEM_Write_Enable = 1'b0;
        tick();
        checks++; if (load_err !== 1'b0 || pc_out !== 32'd3) begin errors++; $display("[TB] FAIL run_write_after: got err=%b pc=%0d want err=0 pc=3", load_err, pc_out); end
        redirect_valid = 1'b1; redirect_pc = 16'd44;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (pc_out !== 32'd44 || instr_out !== prog[44]) begin errors++; $display("[TB] FAIL mem44_intact: got pc=%0d instr=%h want pc=44 instr=%h", pc_out, instr_out, prog[44]); end
    endtask

    task automatic test_redirect_wrap();
        redirect_valid = 1'b1; redirect_pc = 16'h0105; stall = 1'b1;
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL redirect_under_stall: got %b want 0", instr_valid); end
        tick();
        checks++; if (pc_out !== 32'd5 || instr_out !== prog[5]) begin errors++; $display("[TB] FAIL redirect_upper_bits: got pc=%0d instr=%h want pc=5 instr=%h", pc_out, instr_out, prog[5]); end
        redirect_valid = 1'b1; redirect_pc = 16'd250;
        tick();
        redirect_valid = 1'b0;
        for (int i = 250; i < 257; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || pc_out !== 32'(i % DEPTH) || instr_out !== prog[i % DEPTH]) begin
                errors++;
                $display("[TB] FAIL wrap_%0d: got v=%b pc=%0d instr=%h want v=1 pc=%0d instr=%h",
                         i, instr_valid, pc_out, instr_out, i % DEPTH, prog[i % DEPTH]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        redirect_valid = 1'b1; redirect_pc = 16'd10;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (pc_out !== 32'd10) begin errors++; $display("[TB] FAIL pre_reset_pc: got %0d want 10", pc_out); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || pc_out !== 32'd0 || instr_out !== 32'd0 || running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_clear: got v=%b pc=%0d instr=%h run=%b want all 0",
                     instr_valid, pc_out, instr_out, running);
        end
        start = 1'b0;
        tick();
        rst = 1'b0; start = 1'b1;
        tick();
        checks++; if (running !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rerun_entry: got run=%b v=%b want 1 0", running, instr_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || pc_out !== 32'(i) || instr_out !== prog[i]) begin
                errors++;
                $display("[TB] FAIL rerun_%0d: got v=%b pc=%0d instr=%h want v=1 pc=%0d instr=%h",
                         i, instr_valid, pc_out, instr_out, i, prog[i]);
            end
        end
        start = 1'b0;
        tick();
        checks++; if (instr_valid !== 1'b0 || running !== 1'b0) begin errors++; $display("[TB] FAIL final_stop: got v=%b run=%b want 0 0", instr_valid, running); end
        checks++; if (pc_out !== 32'd2 || instr_out !== prog[2]) begin errors++; $display("[TB] FAIL final_hold: got pc=%0d instr=%h want pc=2 instr=%h", pc_out, instr_out, prog[2]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < DEPTH; i++) prog[i] = '0;
        test_reset();
        test_load_and_run();
        test_redirect();
        test_stall();
        test_load_err();
        test_redirect_wrap();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
- Instruction memory and fetch front end for the CPU: the receiving end of the instruction-load port (I_MEM_Write_Enable / I_MEM_Data_In / I_MEM_Write_Addr) that the bench drives before asserting start.
- Stores loaded words, then, once start is seen, streams instructions with their PC to decode.
- Honours stall and branch/jump redirect from the core.
- Sits between the load interface and the CPU decode stage.

Parameters:
DEPTH, 256, instruction words stored (power of two)
AW, 8, log2(DEPTH); index width
DATA_W, 32, instruction width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  global run enable; fetch only while high
I_MEM_Write_Enable  in  1  load-port write strobe
I_MEM_Data_In  in  DATA_W  load-port write data
I_MEM_Write_Addr  in  16  load-port word address
stall  in  1  decode cannot accept; hold outputs
redirect_valid  in  1  branch/jump taken; 1-cycle pulse
redirect_pc  in  16  redirect target word address
instr_out  out  DATA_W  fetched instruction
instr_valid  out  1  instr_out/pc_out valid this cycle
pc_out  out  32  word address of instr_out (zero-extended)
load_err  out  1  1-cycle pulse: write rejected
running  out  1  high in RUN state

Behaviour:
- Reset, asynchronous: state=IDLE; instr_out=0, instr_valid=0, pc_out=0, load_err=0, running=0, fetch_pc=0. Memory array is not cleared; contents survive reset.
- States:
  - IDLE: waiting for load or start.
  - LOAD: I_MEM_Write_Enable high.
  - RUN: fetching.
- IDLE->LOAD when I_MEM_Write_Enable=1. LOAD->IDLE when it drops.
- IDLE->RUN when start=1 and I_MEM_Write_Enable=0. If both are high, LOAD wins; RUN is entered the first cycle after WE drops while start is still high.
- Writes:
  - In IDLE/LOAD with WE=1 and I_MEM_Write_Addr<DEPTH: mem[addr]<=data on that edge.
  - Addr>=DEPTH: write dropped, load_err=1 next cycle for one cycle.
  - WE=1 while in RUN: write dropped, load_err pulses, fetch unaffected.
- Memory read is synchronous with 1-cycle latency: fetch_pc presented at edge t, data at t+1.
- RUN entry: fetch_pc=0. instr_valid=0 on the first RUN cycle. The next cycle gives instr_out=mem[0], pc_out=0, instr_valid=1.
- Steady RUN with no stall: one instruction per cycle, pc_out increments by 1.
- PC wrap: after DEPTH-1 the PC goes to 0. No error is flagged.
- Stall=1: instr_out, pc_out, instr_valid and fetch_pc all hold. The memory read is re-issued for the held address, so nothing is lost when stall releases.
- Redirect:
  - redirect_valid=1 (accepted even if stall=1; redirect has priority): fetch_pc<=redirect_pc[AW-1:0], with upper bits ignored (wrap).
  - Next cycle instr_valid=0 (one bubble). Cycle after: instr_out=mem[target], pc_out=target, instr_valid=1.
  - The instruction on instr_out in the redirect cycle is considered consumed.
- start deasserted in RUN: next edge state=IDLE, instr_valid=0, running=0, fetch_pc=0. instr_out and pc_out keep their last values.
- Reset mid-RUN: immediate IDLE and output clear. A loaded program restarts from 0 on the next start.
- running=1 exactly while state=RUN (registered).

Test Plan:
1. Load the 27-word program (addr 0..26; word 1=0xC8210005), WE low, start=1. Required: instr_valid rises 2 cycles after start; sequence pc 0:0x00000000, pc 1:0xC8210005, pc 2:0xC842000A, one per cycle.
2. While running, pulse redirect_valid with redirect_pc=0 when pc_out=26. Required: one cycle with instr_valid=0, then pc_out=0, instr_out=0x00000000.
3. Hold stall for 3 cycles at pc_out=5. Required: pc_out=5 and instr_out=mem[5] held for all 3 cycles; pc_out=6 on the first cycle after release.
4. Write addr 300 in IDLE, then WE=1 while in RUN. Required: load_err pulses one cycle each; mem[300 mod DEPTH] unchanged; fetch order intact.
5. redirect_pc=0x0105 with DEPTH=256. Required: fetches from 5. With start held and no redirect past pc 255, the next pc_out is 0.
6. Assert rst mid-run at pc_out=10, release, raise start. Required: outputs 0 during reset; restart from pc 0 returns the original loaded words (memory preserved). start low in RUN gives instr_valid=0 the next cycle.
